// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Write-port driver for the CPU instruction/data RAM (clkram).
//             Holds the CPU in PC reset while a framed byte stream is
//             received. Bytes are packed big-endian into 32-bit words, and
//             each word is written to the next RAM address. The CPU is
//             released once the frame is complete.
//             Frame layout: N[15:8], N[7:0], 4*N payload bytes, and then an
//             optional checksum byte.
//  Ports    : clk, rst           - clock and synchronous active-high reset
//             start              - one-cycle pulse, starts a load from idle/done
//             in_valid/in_data   - byte source
//             in_ready           - byte accepted when in_valid && in_ready
//             ram_wena/ram_addr/ram_wdata - clkram write port
//             cpu_hold           - drives pcrst (1 = CPU held in reset)
//             busy/done/ovf      - load status (ovf: N exceeded MAX_WORDS)
//             words_written      - words actually written in this/last load
//             cks_err            - checksum mismatch (macro build only)
//  Macro    : PROG_LOADER_CHECKSUM_EN adds the trailing checksum byte, the
//             CHK state and the cks_err output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ram_wena,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] words_written
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic        cks_err
`endif
);

  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_t;

  // State entered once the payload is exhausted (including the N == 0 case).
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t c_after_payload = S_CHK;
`else
  localparam state_t c_after_payload = S_DONE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [31:0] r_word;
  logic [1:0]  r_bidx;
  logic [15:0] r_widx;
  logic [31:0] r_addr;
  logic [15:0] r_ww;
  logic        r_ovf;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
  logic        r_cks_err;
`endif

  logic        w_xfer;
  logic [15:0] w_len_full;
  logic        w_in_range;
  logic        w_last;

  assign w_xfer     = in_valid && in_ready;
  // The full length is only valid while the low byte is being accepted.
  assign w_len_full = {r_len[15:8], in_data};
  assign w_in_range = ({16'd0, r_widx} < c_max_words);
  // r_len is non-zero whenever WRITE is reachable, so N-1 cannot underflow.
  assign w_last     = (r_widx == (r_len - 16'd1));

  assign ram_addr      = r_addr;
  assign ram_wdata     = r_word;
  assign words_written = r_ww;
  assign ovf           = r_ovf;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign cks_err       = r_cks_err;
`endif

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    ram_wena = 1'b0;
    cpu_hold = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = (w_len_full == 16'd0) ? c_after_payload : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (w_xfer && (r_bidx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        // A reset in this cycle must not let the write through.
        ram_wena = w_in_range && !rst;
        w_next   = w_last ? c_after_payload : S_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        cpu_hold = r_cks_err;
`else
        cpu_hold = 1'b0;
`endif
        if (start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= 16'd0;
      r_word    <= 32'd0;
      r_bidx    <= 2'd0;
      r_widx    <= 16'd0;
      r_addr    <= BASE_ADDR;
      r_ww      <= 16'd0;
      r_ovf     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor     <= 8'd0;
      r_cks_err <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_bidx    <= 2'd0;
            r_widx    <= 16'd0;
            r_addr    <= BASE_ADDR;
            r_ww      <= 16'd0;
            r_ovf     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor     <= 8'd0;
            r_cks_err <= 1'b0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) r_len[15:8] <= in_data;
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= in_data;
            r_ovf      <= ({16'd0, w_len_full} > c_max_words);
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[23:0], in_data};
            r_bidx <= r_bidx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ in_data;
`endif
          end
        end
        S_WRITE: begin
          // The address advances even for suppressed (out-of-range) words.
          if (w_in_range) r_ww <= r_ww + 16'd1;
          r_addr <= r_addr + ADDR_STEP;
          r_widx <= r_widx + 16'd1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) r_cks_err <= (in_data != r_xor);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader. Two instances share the
//             same stimulus: one with the default capacity and one with
//             MAX_WORDS=2. Expected RAM writes are pushed to per-instance
//             queues when a frame is launched. They are popped and compared
//             whenever an instance asserts ram_wena.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready,   in_ready_s;
  logic        ram_wena,   ram_wena_s;
  logic [31:0] ram_addr,   ram_addr_s;
  logic [31:0] ram_wdata,  ram_wdata_s;
  logic        cpu_hold,   cpu_hold_s;
  logic        busy,       busy_s;
  logic        done,       done_s;
  logic        ovf,        ovf_s;
  logic [15:0] words_written, words_written_s;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic        cks_err, cks_err_s;
`endif

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .ovf(ovf), .words_written(words_written)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .cks_err(cks_err)
`endif
  );

  prog_loader #(.MAX_WORDS(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .ram_wena(ram_wena_s), .ram_addr(ram_addr_s), .ram_wdata(ram_wdata_s),
    .cpu_hold(cpu_hold_s), .busy(busy_s), .done(done_s), .ovf(ovf_s), .words_written(words_written_s)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .cks_err(cks_err_s)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         checks   = 0;
  int         failures = 0;
  wr_t        q_main[$];
  wr_t        q_small[$];
  logic [7:0] frame[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ram_wena !== 1'b0) begin
      check("main_write_expected", 32'(q_main.size() > 0), 32'd1);
      if (q_main.size() > 0) begin
        wr_t e;
        e = q_main.pop_front();
        check("main_write_addr", ram_addr, e.addr);
        check("main_write_data", ram_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ram_wena_s !== 1'b0) begin
      check("small_write_expected", 32'(q_small.size() > 0), 32'd1);
      if (q_small.size() > 0) begin
        wr_t e;
        e = q_small.pop_front();
        check("small_write_addr", ram_addr_s, e.addr);
        check("small_write_data", ram_wdata_s, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!(in_ready === 1'b1 && in_ready_s === 1'b1) && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("handshake_in_time", 32'(g < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),      32'd0);
    check({tag, "_ram_wena"},  32'(ram_wena),      32'd0);
    check({tag, "_ram_addr"},  ram_addr,           32'h0000_0000);
    check({tag, "_ram_wdata"}, ram_wdata,          32'd0);
    check({tag, "_cpu_hold"},  32'(cpu_hold),      32'd1);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_ovf"},       32'(ovf),           32'd0);
    check({tag, "_ww"},        32'(words_written), 32'd0);
    check({tag, "_small_wena"}, 32'(ram_wena_s),   32'd0);
    check({tag, "_small_hold"}, 32'(cpu_hold_s),   32'd1);
    check({tag, "_small_ww"},  32'(words_written_s), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check({tag, "_cks_err"},   32'(cks_err),       32'd0);
`endif
  endtask

  // Runs the frame in 'frame'. stall_at >= 0 drops in_valid for 3 cycles
  // before that byte index (and pulses start, which must be ignored).
  // cks_override < 0 sends the correct checksum (macro build only).
  task automatic run_frame(input string tag, input int stall_at, input int cks_override);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int         n_words;
    int         guard;
    logic       exp_cks_err;
    wr_t        e;
    bytes       = frame;
    x           = 8'd0;
    exp_cks_err = 1'b0;
    n_words     = int'({bytes[0], bytes[1]});
    for (int i = 0; i < n_words; i++) begin
      e.addr = 32'(i);
      e.data = {bytes[2+4*i], bytes[3+4*i], bytes[4+4*i], bytes[5+4*i]};
      for (int k = 0; k < 4; k++) x = x ^ bytes[2+4*i+k];
      if (i < 256) q_main.push_back(e);
      if (i < 2)   q_small.push_back(e);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (cks_override < 0) begin
      bytes.push_back(x);
    end else begin
      bytes.push_back(cks_override[7:0]);
      exp_cks_err = (cks_override[7:0] != x);
    end
`endif

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, 32'(busy),          32'd1);
    check({tag, "_start_hold"}, 32'(cpu_hold),      32'd1);
    check({tag, "_start_done"}, 32'(done),          32'd0);
    check({tag, "_start_ovf"},  32'(ovf),           32'd0);
    check({tag, "_start_ww"},   32'(words_written), 32'd0);

    for (int idx = 0; idx < bytes.size(); idx++) begin
      if (idx == stall_at) begin
        in_valid = 1'b0;
        start    = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          start = 1'b0;
          check({tag, "_stall_no_wena"}, 32'(ram_wena), 32'd0);
          check({tag, "_stall_busy"},    32'(busy),     32'd1);
        end
      end
      send_byte(bytes[idx]);
    end

    if (n_words == 0) check({tag, "_empty_done_now"}, 32'(done), 32'd1);

    guard = 0;
    while (!(done === 1'b1 && done_s === 1'b1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"},       32'(done),          32'd1);
    check({tag, "_busy_off"},   32'(busy),          32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),      32'(exp_cks_err));
    check({tag, "_ww"},         32'(words_written), 32'(n_words < 256 ? n_words : 256));
    check({tag, "_ovf"},        32'(ovf),           32'(n_words > 256));
    check({tag, "_small_done"}, 32'(done_s),        32'd1);
    check({tag, "_small_ww"},   32'(words_written_s), 32'(n_words < 2 ? n_words : 2));
    check({tag, "_small_ovf"},  32'(ovf_s),         32'(n_words > 2));
`ifdef PROG_LOADER_CHECKSUM_EN
    check({tag, "_cks_err"},    32'(cks_err),       32'(exp_cks_err));
`endif
    check({tag, "_main_q_empty"},  32'(q_main.size()),  32'd0);
    check({tag, "_small_q_empty"}, 32'(q_small.size()), 32'd0);
    // done must persist while idle in DONE
    @(negedge clk);
    check({tag, "_done_holds"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset_idle");

    // Two-word program
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    run_frame("two_words", -1, -1);

    // Same frame with a 3-cycle stall mid-word (reload from DONE)
    run_frame("stalled", 4, -1);

    // Empty frame
    frame = '{8'h00, 8'h00};
    run_frame("empty", -1, -1);

    // Three words: fits the default instance, overflows the MAX_WORDS=2 one
    frame = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    run_frame("three_words", -1, -1);

    // Reset between the 2nd and 3rd payload bytes: no write may follow
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("abort");
    repeat (3) @(negedge clk);
    check("abort_no_write", 32'(ram_wena), 32'd0);
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    run_frame("after_abort", -1, -1);

`ifdef PROG_LOADER_CHECKSUM_EN
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("cks_good", -1, -1);
    run_frame("cks_bad", -1, 8'h45);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's instruction/data RAM (clkram write port) for the multi-cycle CPU top.
- Holds the CPU in PC reset while it receives a framed byte stream, assembles 32-bit words and writes them to consecutive RAM addresses.
- When the frame is complete it releases the CPU.
- Fills the role of the currently unused pcrst path.

Parameters:
- BASE_ADDR, 32'h0000_0000, RAM address of the first loaded word.
- ADDR_STEP, 1, address increment per word (clkram is word-addressed).
- MAX_WORDS, 256, RAM capacity in words; words beyond this are not written.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE.
- in_valid  in  1  byte source has a byte.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts the byte this cycle; transfer occurs when in_valid && in_ready.
- ram_wena  out  1  write enable to clkram wena.
- ram_addr  out  32  to clkram addr.
- ram_wdata  out  32  to clkram data_in.
- cpu_hold  out  1  drives pcrst; 1 = CPU held at reset.
- busy  out  1  load in progress.
- done  out  1  last load finished.
- ovf  out  1  header length exceeded MAX_WORDS.
- words_written  out  16  words actually written in the current/last load.

Behaviour:
- Reset values: in_ready=0, ram_wena=0, ram_addr=BASE_ADDR, ram_wdata=0, cpu_hold=1, busy=0, done=0, ovf=0, words_written=0. Reset mid-load aborts immediately, with no further RAM write.
- Frame format:
  - 2-byte big-endian word count N.
  - Then 4N payload bytes, each word big-endian: first byte lands in [31:24].
  - Optional checksum byte (see Optional Feature).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE.
- IDLE: cpu_hold=1, in_ready=0. start -> LEN_HI, busy=1, done=0, ovf=0, words_written=0, byte index=0, addr=BASE_ADDR.
- LEN_HI / LEN_LO:
  - in_ready=1; each accepted byte loads N[15:8] / N[7:0].
  - After LEN_LO: N==0 -> CHK (macro on) or DONE (macro off); otherwise -> DATA.
  - ovf is set when N>MAX_WORDS.
- DATA:
  - in_ready=1; accepted bytes shift into the word register (word = {word[23:0], byte}).
  - On the 4th accepted byte -> WRITE.
  - A cycle without in_valid holds state; there is no timeout.
- WRITE: exactly one cycle, in_ready=0.
  - ram_wena=1 only if the word index < MAX_WORDS. When asserted, ram_addr/ram_wdata hold the current address and the assembled word, and words_written increments.
  - ram_addr advances by ADDR_STEP after each word regardless of suppression.
  - Last word (index N-1) -> CHK/DONE; else -> DATA.
- Write timing: one RAM write per 4 accepted bytes. The write occurs in the cycle after the 4th byte handshake.
- DONE:
  - busy=0, done=1, cpu_hold=0; done stays high until rst or start.
  - start in DONE reloads: cpu_hold returns to 1 in the cycle after start.
- start while busy is ignored.
- ram_wena is 0 in every state except WRITE.
- Counters are 16-bit; address arithmetic is 32-bit modulo 2^32 (wraps silently).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro:
  - State CHK is present: in_ready=1 and one extra byte is accepted, then -> DONE.
  - Output cks_err (1 bit, reset 0) is set if that byte != XOR of all payload bytes. The XOR starts at 0; header bytes are excluded.
  - On cks_err, cpu_hold stays 1 in DONE (CPU not released) until the next start or rst.
- Without the macro: no CHK state, no cks_err port, and the frame ends after the payload.

Test Plan:
1. rst, start, stream 00 02 | 20 08 00 05 | AC 08 00 10 -> two writes: addr 0 data 32'h20080005, then addr 1 data 32'hAC080010; done=1, cpu_hold=0, words_written=2.
2. Same frame with in_valid dropped for 3 cycles mid-word -> identical RAM writes; ram_wena never asserted during stall cycles.
3. Frame 00 00 -> no ram_wena, done=1 two handshakes after start, words_written=0.
4. MAX_WORDS=2, header 00 03 plus 12 bytes -> ovf=1, only 2 writes (addr 0, 1), all 12 bytes consumed, done=1.
5. rst asserted between the 2nd and 3rd payload byte -> no write occurs; all outputs at reset values next cycle; a fresh start then loads correctly.
6. With PROG_LOADER_CHECKSUM_EN, frame 00 01 | 11 22 33 44 | 44 -> write 32'h11223344, cks_err=0, cpu_hold=0. Same frame with checksum 45 -> cks_err=1, cpu_hold=1.
